// File: rtl/seven_seg_scan.sv
// Time-multiplexed 4-digit seven-segment driver: shadow-latched BCD digits,
// one digit per DIV_COUNT-cycle slot, leading-zero blanking, dash for non-BCD.
module seven_seg_scan #(
  parameter int DIV_COUNT      = 27000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       blank_lz,
  input  logic [3:0] bcd_thousands,
  input  logic [3:0] bcd_hundreds,
  input  logic [3:0] bcd_tens,
  input  logic [3:0] bcd_ones,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic [1:0] digit_sel,
  output logic       scan_tick
);

  localparam int PW = (DIV_COUNT > 2) ? $clog2(DIV_COUNT) : 1;
  localparam logic [PW-1:0] PLAST   = PW'(DIV_COUNT - 1);
  localparam logic [3:0]    AN_OFF  = AN_ACTIVE_LOW  ? 4'hF  : 4'h0;
  localparam logic [6:0]    SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [PW-1:0]      pcnt;
  logic [1:0]         idx;
  logic [3:0][3:0]    sh;
  logic               wrap;
  logic [1:0]         idx_next;
  logic [3:0]         lz;
  logic [3:0]         cur;
  logic               blank;
  logic [6:0]         enc;
  logic [3:0]         an_raw;
  logic [6:0]         seg_raw;

  assign wrap     = (pcnt == PLAST);
  assign idx_next = wrap ? idx + 2'd1 : idx;

  // A digit is a leading zero only while every higher digit is also zero.
  assign lz[3] = (sh[3] == 4'd0);
  assign lz[2] = lz[3] && (sh[2] == 4'd0);
  assign lz[1] = lz[2] && (sh[1] == 4'd0);
  assign lz[0] = 1'b0;

  // Outputs are computed from the upcoming index so an/seg move with scan_tick.
  assign cur   = sh[idx_next];
  assign blank = blank_lz && lz[idx_next];

  always_comb begin
    enc = 7'h40;
    case (cur)
      4'd0: enc = 7'h3F;
      4'd1: enc = 7'h06;
      4'd2: enc = 7'h5B;
      4'd3: enc = 7'h4F;
      4'd4: enc = 7'h66;
      4'd5: enc = 7'h6D;
      4'd6: enc = 7'h7D;
      4'd7: enc = 7'h07;
      4'd8: enc = 7'h7F;
      4'd9: enc = 7'h6F;
      default: enc = 7'h40;
    endcase
  end

  always_comb begin
    an_raw  = 4'h0;
    seg_raw = 7'h00;
    if (!blank) begin
      an_raw[idx_next] = 1'b1;
      seg_raw          = enc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt      <= '0;
      idx       <= 2'd0;
      sh        <= '0;
      scan_tick <= 1'b0;
      digit_sel <= 2'd0;
      an        <= AN_OFF;
      seg       <= SEG_OFF;
    end else begin
      pcnt      <= wrap ? '0 : pcnt + 1'b1;
      idx       <= idx_next;
      scan_tick <= wrap;
      digit_sel <= idx_next;
      an        <= AN_ACTIVE_LOW  ? ~an_raw  : an_raw;
      seg       <= SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
      if (load) sh <= {bcd_thousands, bcd_hundreds, bcd_tens, bcd_ones};
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed vector bench for seven_seg_scan with DIV_COUNT=4, active-low polarity.
module tb_seven_seg_scan;

  logic       clk = 1'b0;
  logic       rst, load, blank_lz;
  logic [3:0] bcd_thousands, bcd_hundreds, bcd_tens, bcd_ones;
  logic [3:0] an;
  logic [6:0] seg;
  logic [1:0] digit_sel;
  logic       scan_tick;

  int tests = 0;
  int fails = 0;

  seven_seg_scan #(.DIV_COUNT(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .load(load), .blank_lz(blank_lz),
    .bcd_thousands(bcd_thousands), .bcd_hundreds(bcd_hundreds),
    .bcd_tens(bcd_tens), .bcd_ones(bcd_ones),
    .an(an), .seg(seg), .digit_sel(digit_sel), .scan_tick(scan_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] digits;  // {thousands, hundreds, tens, ones}
    logic        blz;
    logic [15:0] an_exp;  // {slot3, slot2, slot1, slot0}
    logic [27:0] seg_exp; // {slot3, slot2, slot1, slot0}
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_digits(input logic [15:0] d);
    {bcd_thousands, bcd_hundreds, bcd_tens, bcd_ones} = d;
  endtask

  // Reset, load on edge 1, then sample each slot at edges 2, 6, 10, 14.
  task automatic run_vec(input int n);
    do_reset();
    set_digits(vecs[n].digits);
    blank_lz = vecs[n].blz;
    load = 1'b1;
    step();
    load = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      if (k != 0) repeat (4) step();
      chk($sformatf("vec%0d slot%0d an", n, k), int'(an), int'(vecs[n].an_exp[k*4 +: 4]));
      chk($sformatf("vec%0d slot%0d seg", n, k), int'(seg), int'(vecs[n].seg_exp[k*7 +: 7]));
      chk($sformatf("vec%0d slot%0d sel", n, k), int'(digit_sel), k);
    end
  endtask

  initial begin
    vecs[0] = '{16'h1234, 1'b0, 16'h7BDE, {7'h79, 7'h24, 7'h30, 7'h19}};
    vecs[1] = '{16'h0040, 1'b1, 16'hFFDE, {7'h7F, 7'h7F, 7'h19, 7'h40}};
    vecs[2] = '{16'h0040, 1'b0, 16'h7BDE, {7'h40, 7'h40, 7'h19, 7'h40}};
    vecs[3] = '{16'h0C00, 1'b1, 16'hFBDE, {7'h7F, 7'h3F, 7'h40, 7'h40}};
    vecs[4] = '{16'h0000, 1'b1, 16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[5] = '{16'h9876, 1'b1, 16'h7BDE, {7'h10, 7'h00, 7'h78, 7'h02}};
    vecs[6] = '{16'hF005, 1'b1, 16'h7BDE, {7'h3F, 7'h40, 7'h40, 7'h12}};

    rst = 1'b1; load = 1'b0; blank_lz = 1'b0;
    set_digits(16'h0000);

    // Reset state and first frame
    step(); step(); step();
    chk("rst an", int'(an), 'hF);
    chk("rst seg", int'(seg), 'h7F);
    chk("rst sel", int'(digit_sel), 0);
    chk("rst tick", int'(scan_tick), 0);
    rst = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      int ix;
      step();
      ix = (e / 4) % 4;
      chk($sformatf("frame e%0d an", e), int'(an), int'(~(4'b0001 << ix) & 4'hF));
      chk($sformatf("frame e%0d tick", e), int'(scan_tick), (e % 4 == 0) ? 1 : 0);
      chk($sformatf("frame e%0d sel", e), int'(digit_sel), ix);
      if (ix == 0) chk($sformatf("frame e%0d seg", e), int'(seg), 'h40);
    end

    for (int n = 0; n < 7; n++) run_vec(n);

    // Load mid-slot: new ones digit shows one cycle after the load edge
    do_reset();
    blank_lz = 1'b0;
    set_digits(16'h0000);
    step();
    chk("mid e1 seg", int'(seg), 'h40);
    set_digits(16'h0009);
    load = 1'b1;
    step();
    load = 1'b0;
    chk("mid e2 seg", int'(seg), 'h40);
    step();
    chk("mid e3 seg", int'(seg), 'h10);
    chk("mid e3 tick", int'(scan_tick), 0);
    chk("mid e3 an", int'(an), 'hE);
    step();
    chk("mid e4 tick", int'(scan_tick), 1);
    chk("mid e4 an", int'(an), 'hD);

    // Reset mid-frame with a concurrent load that must be ignored
    do_reset();
    set_digits(16'h1234);
    load = 1'b1;
    step();
    load = 1'b0;
    repeat (8) step();
    chk("rmid pre an", int'(an), 'hB);
    chk("rmid pre seg", int'(seg), 'h24);
    set_digits(16'h5555);
    rst = 1'b1;
    load = 1'b1;
    step();
    chk("rmid an", int'(an), 'hF);
    chk("rmid seg", int'(seg), 'h7F);
    chk("rmid sel", int'(digit_sel), 0);
    chk("rmid tick", int'(scan_tick), 0);
    rst = 1'b0;
    load = 1'b0;
    step();
    chk("rmid post an", int'(an), 'hE);
    chk("rmid post seg", int'(seg), 'h40);
    repeat (4) step();
    chk("rmid tens an", int'(an), 'hD);
    chk("rmid tens seg", int'(seg), 'h40);

    // blank_lz dropped during a blanked slot un-blanks on the next edge
    do_reset();
    set_digits(16'h0040);
    blank_lz = 1'b1;
    load = 1'b1;
    step();
    load = 1'b0;
    repeat (9) step();
    chk("blz on an", int'(an), 'hF);
    chk("blz on seg", int'(seg), 'h7F);
    blank_lz = 1'b0;
    step();
    chk("blz off an", int'(an), 'hB);
    chk("blz off seg", int'(seg), 'h40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Time-multiplexed 4-digit seven-segment display driver. It sits directly downstream of the binary-to-BCD converter and takes its four BCD digits (thousands, hundreds, tens, ones). It latches them into shadow registers on a load strobe and scans one digit per refresh period onto shared segment lines. It also provides leading-zero blanking and shows a dash for non-BCD codes.

## Interface
- `DIV_COUNT`, default 27000: clock cycles per digit slot (27 MHz → 1 kHz per digit). Legal range ≥ 2.
- `SEG_ACTIVE_LOW`, default 1: 1 means a lit segment is driven 0.
- `AN_ACTIVE_LOW`, default 1: 1 means the selected anode is driven 0.
- `clk` in 1: system clock. Single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `load` in 1: capture strobe for the four digit inputs.
- `blank_lz` in 1: enables leading-zero blanking.
- `bcd_thousands` in 4: digit 3.
- `bcd_hundreds` in 4: digit 2.
- `bcd_tens` in 4: digit 1.
- `bcd_ones` in 4: digit 0.
- `an` out 4: anode enables. Bit i selects digit i. One-hot active, or all inactive.
- `seg` out 7: segment lines as {g,f,e,d,c,b,a}.
- `digit_sel` out 2: index of the digit currently driven.
- `scan_tick` out 1: one-cycle pulse at each slot advance.

## Operation
- **Shadow registers**
  - `sh[3:0]` is four 4-bit registers.
  - When `load`=1 on an edge, `sh` captures all four inputs simultaneously.
  - When `load`=0, `sh` holds. Inputs are ignored unless `load` is high.
- **Prescaler**
  - `pcnt` counts 0..DIV_COUNT-1 and wraps to 0.
  - `scan_tick`=1 (registered) in the cycle after `pcnt` reaches DIV_COUNT-1.
- **Digit index**
  - `idx` advances on each tick: 0→1→2→3→0 (ones, tens, hundreds, thousands).
  - `digit_sel`=`idx`.
- **Segment encoding**, active-high form, before polarity:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Codes 10–15 map to dash = 40.
  - If `SEG_ACTIVE_LOW`, `seg` is the bitwise inverse.
- **Blanking** (only when `blank_lz`=1). Digit i is blanked iff `sh[i]`==0 and every higher digit is also 0:
  - Thousands is blanked if `sh[3]`==0.
  - Hundreds is blanked if `sh[3]` and `sh[2]` are 0.
  - Tens is blanked if `sh[3..1]` are 0.
  - Ones is never blanked.
  - Codes 10–15 count as nonzero.
- **Blanked slot**: `an` is all inactive and `seg` is all off. `idx` still advances, so slot timing is unchanged.
- **Normal slot**: `an` has only bit `idx` active; `seg` carries the encoding of `sh[idx]`.
- **Reset** (including mid-scan) forces, on the next edge:
  - `pcnt`=0, `idx`=0, `sh`=0, `scan_tick`=0, `digit_sel`=0.
  - `an` all inactive, `seg` all off.
  - `rst` has priority over `load`.

## Timing
- All outputs are registered. No combinational path from input to output.
- After `rst` deasserts, the first edge drives digit 0 (`sh`=0 → shows "0" on ones).
- Slot length is exactly DIV_COUNT cycles. A full frame is 4·DIV_COUNT cycles.
- `idx` and `an` change on the same edge as `scan_tick` rises.
- **Load latency**: `load` sampled at edge N updates `sh` at N. If the current slot's digit changed, `seg`/`an` reflect it at edge N+1, without waiting for a tick.
- **`load` held high**: `sh` tracks inputs every cycle, still with one-cycle output latency.
- **`load` coincident with a tick**: the new `idx` and the new `sh` take effect together at N+1.
- **`blank_lz` changes** take effect at the next edge.

## Test plan
- **Reset and first frame**: DIV_COUNT=4, `rst` high 3 cycles then low, no load → `an`=1111, `seg`=7F during reset. Then cycle 1: `an`=1110, `seg`=40 (inverted 3F). `an` advances every 4 cycles through 1101, 1011, 0111, and `scan_tick` pulses every 4 cycles.
- **Full value**: load {1,2,3,4}, `blank_lz`=0 → slots show ones=4 (seg 19), tens=3 (seg 30), hundreds=2 (seg 24), thousands=1 (seg 79) with active-low polarity.
- **Blanking**: load {0,0,4,0}, `blank_lz`=1 → thousands and hundreds slots `an`=1111; tens shows 4, ones shows 0. Same digits with `blank_lz`=0 → all four anodes active.
- **Invalid code**: load {0,0xC,0,0}, `blank_lz`=1 → hundreds shows dash (active-low seg 3F) and is not blanked; tens and ones show 0.
- **Load mid-slot**: during the ones slot, load ones=9 → `seg` becomes 10 one cycle after the load edge; slot length unaffected.
- **Reset mid-frame**: assert `rst` while on the hundreds slot → next edge `an`=1111, `digit_sel`=0, `sh` cleared; `load` asserted concurrently is ignored.
